inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//   Instruction queue between the fetch stage (I-cache return path) and the
//   main decoder: accepts up to two instructions per cycle from fetch and
//   presents exactly one instruction per cycle on instrD. It decouples I-cache
//   latency from decode stalls. Flush on exception, eret or branch redirect.
// PARAMETERS
//   DEPTH  16  queue entries; power of two, >= 4
//   AW     4   pointer width = log2(DEPTH); count width is AW+1
// PORTS
//   clk           in   1   rising-edge clock
//   resetn        in   1   asynchronous, active-low reset
//   flush         in   1   discard all entries (exception/eret/redirect)
//   fetch_valid0  in   1   slot0 carries an instruction (older of the pair)
//   fetch_valid1  in   1   slot1 carries an instruction (younger)
//   fetch_inst0   in   32  slot0 instruction word
//   fetch_inst1   in   32  slot1 instruction word
//   fetch_pc0     in   32  slot0 PC
//   fetch_pc1     in   32  slot1 PC
//   fetch_adel0   in   1   slot0 fetch address error
//   fetch_adel1   in   1   slot1 fetch address error
//   fetch_ready   out  1   queue can accept two entries this cycle
//   stallD        in   1   decode stage holds current instruction
//   validD        out  1   instrD/pcD/adelD hold a real instruction
//   instrD        out  32  instruction to the main decoder
//   pcD           out  32  PC of instrD
//   adelD         out  1   fetch address error flag of instrD
//   count         out  AW+1 current occupancy (0..DEPTH)
// BEHAVIOUR
//   - Storage: circular buffer; wr_ptr/rd_ptr AW bits, wrap modulo DEPTH;
//     count registered. Reset: ptrs=0, count=0, all entry contents 0.
//   - fetch_ready = (count <= DEPTH-2); combinational from registered count.
//   - Push accepted only when fetch_ready=1 and flush=0; otherwise both slots
//     are dropped entirely (no partial write).
//   - Write order: if valid0, slot0 -> mem[wr_ptr]; valid1 goes to the next
//     free position after it (mem[wr_ptr+valid0]). valid1 without valid0 is
//     legal: slot1 written at mem[wr_ptr]. wr_ptr += valid0+valid1.
//   - Read is first-word-fall-through: validD = (count != 0); instrD/pcD/adelD
//     = mem[rd_ptr] when validD, else instrD=32'h0 (SLL $0 NOP), pcD=0,
//     adelD=0. Zero-latency: an entry pushed at edge N is on instrD after N.
//   - Pop = validD & ~stallD & ~flush; rd_ptr += 1. Pop on empty: no effect.
//   - Simultaneous push and pop: count <= count + pushes - pop; legal at
//     any occupancy where fetch_ready=1 (incl. count=DEPTH-2 -> DEPTH-1).
//   - count never exceeds DEPTH; with fetch_ready gating, max after a
//     cycle is DEPTH.
//   - flush=1 at edge N: ptrs and count -> 0; same-cycle push/pop discarded;
//     validD=0 after edge N. Flush has priority over every other event.
//   - Reset asserted mid-operation: immediate clear regardless of clk;
//     validD=0, fetch_ready=1 while resetn=0.
//   - stallD has no effect on acceptance; only fetch_ready gates fetch.
// TESTING
//   1 Reset: resetn=0 -> validD=0, instrD=0, count=0, fetch_ready=1.
//   2 Dual push 0x24020001@0xBFC00000, 0x24030002@0xBFC00004, stallD=0 ->
//     next cycles instrD=0x24020001 then 0x24030002, then validD=0.
//   3 stallD=1, push pairs until count=15 -> fetch_ready=0 at count 15 and 16
//     pushes at count 15 dropped; release stall -> 15 pops in push order.
//   4 Wrap: 40 single pushes with continuous pop -> order and PCs preserved
//     across pointer wrap; count stays <= 1.
//   5 Flush with valid0/1=1 and pop same cycle -> count=0, validD=0 next
//     cycle, none of the pushed words ever appear.
//   6 Push valid1 only with adel1=1 -> instrD=inst1, pcD=pc1, adelD=1.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode bus for the instruction queue.
//   Fetch side: two instruction slots per cycle, valid/inst/pc/adel for each
//               slot; fetch_ready is returned by the queue.
//   Decode side: stallD goes into the queue; validD/instrD/pcD/adelD come out.
//   master = fetch stage + decoder (the testbench); slave = the queue.
interface inst_fetch_queue_if;
  logic        fetch_valid0;
  logic        fetch_valid1;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic [31:0] fetch_pc0;
  logic [31:0] fetch_pc1;
  logic        fetch_adel0;
  logic        fetch_adel1;
  logic        fetch_ready;
  logic        stallD;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        adelD;

  modport master (
    output fetch_valid0, fetch_valid1, fetch_inst0, fetch_inst1,
           fetch_pc0, fetch_pc1, fetch_adel0, fetch_adel1, stallD,
    input  fetch_ready, validD, instrD, pcD, adelD
  );

  modport slave (
    input  fetch_valid0, fetch_valid1, fetch_inst0, fetch_inst1,
           fetch_pc0, fetch_pc1, fetch_adel0, fetch_adel1, stallD,
    output fetch_ready, validD, instrD, pcD, adelD
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction queue between the I-cache return path and the main decoder.
// Accepts up to two instructions per cycle and presents one per cycle
// (first-word-fall-through), so decode stalls do not back up the I-cache.
//   clk, resetn : clock, asynchronous active-low reset
//   flush       : drop all entries (exception / eret / redirect)
//   bus         : inst_fetch_queue_if.slave (fetch slots in, decode slot out)
//   count       : current occupancy, 0..DEPTH
module inst_fetch_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  inst_fetch_queue_if.slave    bus,
  output logic [AW:0]          count
);
  localparam int SLOTS = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  entry_t [SLOTS-1:0]   slot;
  logic   [SLOTS-1:0]   slot_vld;
  logic   [SLOTS-1:0][AW-1:0] slot_idx;
  logic                 push_ok, pop;
  logic   [1:0]         n_push;
  entry_t               head;

  assign slot[0]  = '{inst: bus.fetch_inst0, pc: bus.fetch_pc0, adel: bus.fetch_adel0};
  assign slot[1]  = '{inst: bus.fetch_inst1, pc: bus.fetch_pc1, adel: bus.fetch_adel1};
  assign slot_vld = {bus.fetch_valid1, bus.fetch_valid0};

  // Slot1 packs right behind slot0, or takes wr_ptr itself when slot0 is empty.
  assign slot_idx[0] = wr_ptr;
  assign slot_idx[1] = wr_ptr + AW'(slot_vld[0]);

  assign bus.fetch_ready = (count <= (AW+1)'(DEPTH - 2));
  assign push_ok = bus.fetch_ready & ~flush;
  assign n_push  = push_ok ? ({1'b0, slot_vld[0]} + {1'b0, slot_vld[1]}) : 2'd0;

  assign bus.validD = (count != '0);
  assign pop        = bus.validD & ~bus.stallD & ~flush;

  assign head       = mem[rd_ptr];
  // Empty queue presents a zero word (SLL $0 NOP) so decode sees a bubble.
  assign bus.instrD = bus.validD ? head.inst : 32'h0;
  assign bus.pcD    = bus.validD ? head.pc   : 32'h0;
  assign bus.adelD  = bus.validD & head.adel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int s = 0; s < SLOTS; s++)
        if (push_ok && slot_vld[s]) mem[slot_idx[s]] <= slot[s];
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(n_push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   cnt;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus.slave), .count(cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic        v0, v1, st, fl, a0, a1;
    logic [31:0] i0, i1, p0, p1;
    logic        e_valid;
    logic [31:0] e_instr, e_pc;
    logic        e_adel;
    int          e_count;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, v1, input logic [31:0] i0, i1, p0, p1,
                       input logic a0, a1, st, fl);
    bus.fetch_valid0 = v0;  bus.fetch_valid1 = v1;
    bus.fetch_inst0  = i0;  bus.fetch_inst1  = i1;
    bus.fetch_pc0    = p0;  bus.fetch_pc1    = p1;
    bus.fetch_adel0  = a0;  bus.fetch_adel1  = a1;
    bus.stallD       = st;  flush            = fl;
  endtask

  task automatic idle(input logic st);
    drive(0, 0, 0, 0, 0, 0, 0, 0, st, 0);
  endtask

  // Reference: a FIFO of instructions. Flush empties it; otherwise the head
  // leaves if present and not stalled, and new slots join in age order when
  // at least two spaces are free.
  task automatic model_step();
    if (flush) q.delete();
    else begin
      bit room = (q.size() <= DEPTH - 2);
      if (q.size() != 0 && !bus.stallD) void'(q.pop_front());
      if (room) begin
        if (bus.fetch_valid0) q.push_back('{bus.fetch_inst0, bus.fetch_pc0, bus.fetch_adel0});
        if (bus.fetch_valid1) q.push_back('{bus.fetch_inst1, bus.fetch_pc1, bus.fetch_adel1});
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    bit v = (q.size() != 0);
    chk({tag, ".validD"}, 32'(bus.validD), 32'(v));
    chk({tag, ".instrD"}, bus.instrD, v ? q[0].inst : 32'h0);
    chk({tag, ".pcD"},    bus.pcD,    v ? q[0].pc   : 32'h0);
    chk({tag, ".adelD"},  32'(bus.adelD), v ? 32'(q[0].adel) : 32'h0);
    chk({tag, ".count"},  32'(cnt), 32'(q.size()));
    chk({tag, ".ready"},  32'(bus.fetch_ready), 32'(q.size() <= DEPTH - 2));
  endtask

  initial begin
    int k;
    idle(0);

    // Reset state while resetn is held low.
    @(negedge clk);
    chk("rst.validD", 32'(bus.validD), 0);
    chk("rst.instrD", bus.instrD, 0);
    chk("rst.count",  32'(cnt), 0);
    chk("rst.ready",  32'(bus.fetch_ready), 1);
    resetn = 1'b1;
    @(negedge clk);

    // Directed vectors: inputs applied for one cycle, outputs after the edge.
    vecs.push_back('{1,1,0,0,0,0, 32'h24020001,32'h24030002,32'hBFC00000,32'hBFC00004, 1,32'h24020001,32'hBFC00000,0,2});
    vecs.push_back('{0,0,0,0,0,0, 0,0,0,0,                                             1,32'h24030002,32'hBFC00004,0,1});
    vecs.push_back('{0,0,0,0,0,0, 0,0,0,0,                                             0,32'h0,32'h0,0,0});
    vecs.push_back('{0,1,1,0,0,1, 32'hDEAD0000,32'h8C010000,32'h0,32'hBFC00010,        1,32'h8C010000,32'hBFC00010,1,1});
    vecs.push_back('{0,0,0,0,0,0, 0,0,0,0,                                             0,32'h0,32'h0,0,0});
    vecs.push_back('{1,1,0,1,0,0, 32'hAAAA0001,32'hAAAA0002,32'h1000,32'h1004,         0,32'h0,32'h0,0,0});
    vecs.push_back('{0,0,0,0,0,0, 0,0,0,0,                                             0,32'h0,32'h0,0,0});
    vecs.push_back('{1,1,1,0,0,0, 32'h11110001,32'h11110002,32'h2000,32'h2004,         1,32'h11110001,32'h2000,0,2});
    vecs.push_back('{1,1,0,1,0,0, 32'hBBBB0001,32'hBBBB0002,32'h3000,32'h3004,         0,32'h0,32'h0,0,0});
    vecs.push_back('{0,0,0,0,0,0, 0,0,0,0,                                             0,32'h0,32'h0,0,0});
    foreach (vecs[i]) begin
      drive(vecs[i].v0, vecs[i].v1, vecs[i].i0, vecs[i].i1, vecs[i].p0, vecs[i].p1,
            vecs[i].a0, vecs[i].a1, vecs[i].st, vecs[i].fl);
      cyc();
      chk($sformatf("vec%0d.validD", i), 32'(bus.validD), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.instrD", i), bus.instrD, vecs[i].e_instr);
      chk($sformatf("vec%0d.pcD", i),    bus.pcD,    vecs[i].e_pc);
      chk($sformatf("vec%0d.adelD", i),  32'(bus.adelD), 32'(vecs[i].e_adel));
      chk($sformatf("vec%0d.count", i),  32'(cnt), 32'(vecs[i].e_count));
    end

    // Fill under stall to 15, pushes at 15 dropped, then drain in order.
    k = 0;
    for (int p = 0; p < 7; p++) begin
      drive(1, 1, 32'h30000000 + k, 32'h30000001 + k, 32'h00400000 + 4*k,
            32'h00400004 + 4*k, 0, 0, 1, 0);
      k += 2;
      cyc();
      check_model("fill");
    end
    drive(1, 0, 32'h30000000 + k, 0, 32'h00400000 + 4*k, 0, 0, 0, 1, 0);
    cyc();
    chk("fill15.count", 32'(cnt), 15);
    chk("fill15.ready", 32'(bus.fetch_ready), 0);
    drive(1, 1, 32'hCCCC0001, 32'hCCCC0002, 32'h5000, 32'h5004, 0, 0, 1, 0);
    cyc();
    chk("drop15.count", 32'(cnt), 15);
    check_model("drop15");
    idle(0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("drain%0d.instrD", i), bus.instrD, 32'h30000000 + i);
      chk($sformatf("drain%0d.pcD", i),    bus.pcD,    32'h00400000 + 4*i);
      cyc();
    end
    chk("drain.validD", 32'(bus.validD), 0);
    check_model("drained");

    // Full to 16 under stall, then flush.
    for (int p = 0; p < 8; p++) begin
      drive(1, 1, 32'h40000000 + 2*p, 32'h40000001 + 2*p, 32'h6000 + 8*p,
            32'h6004 + 8*p, 0, 0, 1, 0);
      cyc();
    end
    chk("full16.count", 32'(cnt), 16);
    chk("full16.ready", 32'(bus.fetch_ready), 0);
    drive(1, 1, 32'hEEEE0001, 32'hEEEE0002, 0, 0, 0, 0, 0, 1);
    cyc();
    check_model("flush16");

    // Pointer wrap: single pushes with continuous pop.
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 32'h50000000 + i, 0, 32'h00800000 + 4*i, 0, 0, 0, 0, 0);
      cyc();
      chk($sformatf("wrap%0d.instrD", i), bus.instrD, 32'h50000000 + i);
      chk($sformatf("wrap%0d.pcD", i),    bus.pcD,    32'h00800000 + 4*i);
      chk($sformatf("wrap%0d.cnt_le1", i), 32'(cnt <= 1), 1);
    end
    idle(0);
    cyc();
    check_model("wrap_end");

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom,
            $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0));
      cyc();
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-operation.
    drive(1, 1, 32'h77770001, 32'h77770002, 0, 4, 0, 0, 1, 0);
    cyc();
    idle(1);
    #2 resetn = 1'b0;
    #1;
    q.delete();
    chk("arst.validD", 32'(bus.validD), 0);
    chk("arst.count",  32'(cnt), 0);
    chk("arst.ready",  32'(bus.fetch_ready), 1);
    @(negedge clk);
    resetn = 1'b1;
    idle(0);
    cyc();
    check_model("post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
